// File: rtl/stopwatch_ctrl_pkg.sv
// rtl/stopwatch_ctrl_pkg.sv - shared state encodings and helpers for the stopwatch control sequencer
// Purpose: state type, state width and state decode helpers used by stopwatch_ctrl.
// Ports: none (package).
package stopwatch_ctrl_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } state_t;

   // The prescaler advances (and the counter is fed) in both RUN and LAP.
   function automatic logic is_running(input state_t s);
      return (s == ST_RUN) || (s == ST_LAP);
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// rtl/stopwatch_ctrl_btn_debounce.sv - button synchroniser, debouncer and press one-shot
// Purpose: turns one raw asynchronous button into a single-cycle press pulse.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   btn    in   raw button level, active-high, asynchronous
//   press  out  1-cycle pulse on each debounced rising edge
module btn_debounce #(
   parameter int DB_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   localparam int             CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0]  LAST = CW'(DB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;

   // cnt counts consecutive synced samples that disagree with the debounced
   // level; the DB_CYCLES-th such sample flips the level.  Any agreeing
   // sample restarts the count, which is what rejects short glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            cnt   <= '0;
            level <= sync2;
            press <= sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control sequencer: buttons, RUN/PAUSE/LAP FSM, tick prescaler
// Purpose: conditions the three buttons, sequences the stopwatch states, feeds
//          the seconds counter and owns the frozen lap display value.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start_stop_btn   raw start/stop button
//   reset_btn        raw clear button
//   lap_btn          raw lap button
//   seconds_in       live count from the seconds counter
//   count_en         1-cycle increment strobe to the counter
//   clear            1-cycle synchronous clear strobe to the counter
//   display          live value, or the frozen lap value while in LAP
//   running          1 in RUN or LAP
//   lap_active       1 in LAP
//   state            IDLE=00, RUN=01, PAUSE=10, LAP=11
module stopwatch_ctrl
   import stopwatch_ctrl_pkg::*;
#(
   parameter int CLK_HZ    = 10,
   parameter int DB_CYCLES = 2,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_stop_btn,
   input  logic             reset_btn,
   input  logic             lap_btn,
   input  logic [CNT_W-1:0] seconds_in,
   output logic             count_en,
   output logic             clear,
   output logic [CNT_W-1:0] display,
   output logic             running,
   output logic             lap_active,
   output logic [1:0]       state
);

   localparam int            PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);

   state_t        st;
   logic [PW-1:0] presc;
   logic          start_press;
   logic          reset_press;
   logic          lap_press;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_start_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (start_stop_btn),
      .press (start_press)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_reset_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (reset_btn),
      .press (reset_press)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_lap_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (lap_btn),
      .press (lap_press)
   );

   // count_en is registered from the prescaler's last value, so the first
   // strobe lands CLK_HZ cycles after RUN is entered with the prescaler at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= ST_IDLE;
         presc    <= '0;
         count_en <= 1'b0;
         clear    <= 1'b0;
         display  <= '0;
      end else begin
         count_en <= is_running(st) && (presc == PRE_LAST) && !reset_press;
         clear    <= reset_press;
         if (reset_press) begin
            // Reset outranks every other press in the same cycle.
            st      <= ST_IDLE;
            presc   <= '0;
            display <= seconds_in;
         end else begin
            // PAUSE keeps the partial second; IDLE pins the prescaler at 0.
            if (is_running(st)) begin
               presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
            end else if (st == ST_IDLE) begin
               presc <= '0;
            end
            display <= seconds_in;
            case (st)
               ST_IDLE: begin
                  if (start_press) st <= ST_RUN;
               end
               ST_RUN: begin
                  if (start_press)    st <= ST_PAUSE;
                  else if (lap_press) st <= ST_LAP;
               end
               ST_PAUSE: begin
                  if (start_press) st <= ST_RUN;
               end
               ST_LAP: begin
                  // Staying in LAP freezes the value captured on entry.
                  if (start_press)    st <= ST_PAUSE;
                  else if (lap_press) st <= ST_RUN;
                  else                display <= display;
               end
            endcase
         end
      end
   end

   assign state      = st;
   assign running    = is_running(st);
   assign lap_active = (st == ST_LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl against a behavioural model
module tb_stopwatch_ctrl;

   localparam int CLK_HZ = 10;
   localparam int DB     = 2;
   localparam int W      = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_stop_btn = 1'b0;
   logic         reset_btn = 1'b0;
   logic         lap_btn = 1'b0;
   logic [W-1:0] seconds_in = '0;
   logic         count_en;
   logic         clear;
   logic [W-1:0] display;
   logic         running;
   logic         lap_active;
   logic [1:0]   state;

   always #5 clk = ~clk;

   stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .DB_CYCLES(DB), .CNT_W(W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_stop_btn (start_stop_btn),
      .reset_btn      (reset_btn),
      .lap_btn        (lap_btn),
      .seconds_in     (seconds_in),
      .count_en       (count_en),
      .clear          (clear),
      .display        (display),
      .running        (running),
      .lap_active     (lap_active),
      .state          (state)
   );

   typedef struct packed {
      logic         count_en;
      logic         clear;
      logic [W-1:0] display;
      logic         running;
      logic         lap_active;
      logic [1:0]   state;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: raw sample history per button, debounced levels,
   // previous-cycle presses, and state as plain integers 0..3.
   logic [2:0]   hist [0:7];
   logic [2:0]   m_db;
   logic [2:0]   m_pr;
   int           m_st;
   int           m_presc;
   logic [W-1:0] m_disp;
   int           m_sec;
   exp_t         last_exp;

   task automatic model_clear();
      for (int j = 0; j < 8; j++) hist[j] = 3'b000;
      m_db    = 3'b000;
      m_pr    = 3'b000;
      m_st    = 0;
      m_presc = 0;
      m_disp  = '0;
   endtask

   task automatic model_step(output exp_t e);
      logic [2:0] np;
      int         old;
      bit         run_old;
      bit         on;
      bit         off;
      if (!rst_n) begin
         model_clear();
         e = '0;
         return;
      end
      for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = {lap_btn, reset_btn, start_stop_btn};
      // A press is recorded when the DB samples seen through the 2-FF
      // synchroniser (raw history 2..DB+1 edges back) are all high while the
      // debounced level is low.
      np = 3'b000;
      for (int b = 0; b < 3; b++) begin
         on  = 1'b1;
         off = 1'b1;
         for (int j = 2; j <= DB + 1; j++) begin
            if (hist[j][b]) off = 1'b0;
            else            on  = 1'b0;
         end
         if (!m_db[b] && on) begin
            m_db[b] = 1'b1;
            np[b]   = 1'b1;
         end else if (m_db[b] && off) begin
            m_db[b] = 1'b0;
         end
      end
      old     = m_st;
      run_old = (old == 1) || (old == 3);
      e.count_en = run_old && (m_presc == CLK_HZ - 1) && !m_pr[1];
      e.clear    = m_pr[1];
      if (m_pr[1]) begin
         m_st    = 0;
         m_presc = 0;
      end else begin
         if (run_old)       m_presc = (m_presc + 1) % CLK_HZ;
         else if (old == 0) m_presc = 0;
         if (m_pr[0]) begin
            m_st = run_old ? 2 : 1;
         end else if (m_pr[2]) begin
            if (old == 1)      m_st = 3;
            else if (old == 3) m_st = 1;
         end
      end
      if (!(old == 3 && m_st == 3)) m_disp = seconds_in;
      e.display    = m_disp;
      e.state      = 2'(m_st);
      e.running    = (m_st == 1) || (m_st == 3);
      e.lap_active = (m_st == 3);
      m_pr = np;
   endtask

   task automatic chk(input string name, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
      end
   endtask

   // Monitor: outputs are presented every cycle; compare them mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("count_en",   int'(count_en),   int'(e.count_en));
         chk("clear",      int'(clear),      int'(e.clear));
         chk("display",    int'(display),    int'(e.display));
         chk("running",    int'(running),    int'(e.running));
         chk("lap_active", int'(lap_active), int'(e.lap_active));
         chk("state",      int'(state),      int'(e.state));
      end
   end

   // One clock: predict this edge, then (2 units later) drive the next inputs.
   // The seconds counter is emulated here from the predicted strobes.
   task automatic step(input logic ss, input logic rs, input logic lp);
      exp_t e;
      exp_t used;
      @(posedge clk);
      model_step(e);
      exp_q.push_back(e);
      used     = last_exp;
      last_exp = e;
      #2;
      if (used.clear)         m_sec = 0;
      else if (used.count_en) m_sec = (m_sec + 1) % 256;
      seconds_in     = W'(m_sec);
      start_stop_btn = ss;
      reset_btn      = rs;
      lap_btn        = lp;
   endtask

   task automatic hold(input logic ss, input logic rs, input logic lp, input int n);
      repeat (n) step(ss, rs, lp);
   endtask

   // Asserted between edges: outputs must go to reset values before the next edge.
   task automatic async_reset(input int n);
      rst_n = 1'b0;
      model_clear();
      exp_q[exp_q.size()-1] = '0;
      last_exp = '0;
      hold(1'b0, 1'b0, 1'b0, n);
      rst_n = 1'b1;
   endtask

   initial begin
      model_clear();
      m_sec    = 0;
      last_exp = '0;
      // Power-on reset, then idle.
      hold(1'b0, 1'b0, 1'b0, 3);
      rst_n = 1'b1;
      hold(1'b0, 1'b0, 1'b0, 50);
      // Start from IDLE, then let it count.
      hold(1'b1, 1'b0, 1'b0, 4);
      hold(1'b0, 1'b0, 1'b0, 60);
      // Single-cycle glitches on start and reset.
      hold(1'b1, 1'b0, 1'b0, 1);
      hold(1'b0, 1'b0, 1'b0, 10);
      hold(1'b0, 1'b1, 1'b0, 1);
      hold(1'b0, 1'b0, 1'b0, 10);
      // Pause mid-second, wait, resume.
      hold(1'b1, 1'b0, 1'b0, 4);
      hold(1'b0, 1'b0, 1'b0, 30);
      hold(1'b1, 1'b0, 1'b0, 4);
      hold(1'b0, 1'b0, 1'b0, 20);
      // Lap in, lap out; lap in, start out; lap ignored in PAUSE.
      m_sec = 7;
      hold(1'b0, 1'b0, 1'b1, 3);
      hold(1'b0, 1'b0, 1'b0, 30);
      hold(1'b0, 1'b0, 1'b1, 3);
      hold(1'b0, 1'b0, 1'b0, 10);
      hold(1'b0, 1'b0, 1'b1, 3);
      hold(1'b0, 1'b0, 1'b0, 10);
      hold(1'b1, 1'b0, 1'b0, 3);
      hold(1'b0, 1'b0, 1'b0, 10);
      hold(1'b0, 1'b0, 1'b1, 3);
      hold(1'b0, 1'b0, 1'b0, 10);
      // Start and reset together while running.
      hold(1'b1, 1'b0, 1'b0, 3);
      hold(1'b0, 1'b0, 1'b0, 15);
      hold(1'b1, 1'b1, 1'b0, 3);
      hold(1'b0, 1'b0, 1'b0, 15);
      // Asynchronous reset in the middle of LAP.
      hold(1'b1, 1'b0, 1'b0, 3);
      hold(1'b0, 1'b0, 1'b0, 12);
      hold(1'b0, 1'b0, 1'b1, 3);
      hold(1'b0, 1'b0, 1'b0, 8);
      async_reset(3);
      hold(1'b0, 1'b0, 1'b0, 10);
      // Randomised button activity, counter jumps and occasional resets.
      for (int i = 0; i < 400; i++) begin
         logic ss;
         logic rs;
         logic lp;
         ss = 1'($urandom_range(0, 1));
         rs = ($urandom_range(0, 7) == 0);
         lp = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 40) == 0) m_sec = $urandom_range(0, 255);
         hold(ss, rs, lp, $urandom_range(1, 8));
         if ($urandom_range(0, 80) == 0) async_reset($urandom_range(1, 3));
      end
      hold(1'b0, 1'b0, 1'b0, 4);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
